// File: rtl/sample_buffer_ctrl.sv
// Circular sample buffer for one channel of an I2S stereo stream, with a
// registered read port presenting samples to a valid/ready consumer.
module sample_buffer_ctrl #(
  parameter int unsigned DEPTH       = 256,
  parameter logic        SELECT_LEFT = 1'b1,
  parameter int unsigned READY_LEVEL = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     sample_valid_i,
  input  logic [23:0]              left_sample_i,
  input  logic [23:0]              right_sample_i,
  input  logic                     flush_i,
  output logic [23:0]              read_data_o,
  output logic                     read_valid_o,
  input  logic                     read_ready_i,
  output logic                     buffer_ready_o,
  output logic [$clog2(DEPTH):0]   fill_level_o,
  output logic                     overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] READY_C = CW'(READY_LEVEL);

  logic [23:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] mem_cnt_q, mem_cnt_d;
  logic          read_valid_q, read_valid_d;
  logic [23:0]   read_data_q, read_data_d;
  logic          overflow_q, overflow_d;

  logic [23:0]   sample_sel;
  logic          full;
  logic          handshake;
  logic          do_write;
  logic          do_fetch;

  // Consumer handshake: a sample transfers on any edge where read_valid_o and
  // read_ready_i are both high; while read_valid_o is high and read_ready_i is
  // low, read_data_o and read_valid_o are held unchanged.
  always_comb begin
    sample_sel = SELECT_LEFT ? left_sample_i : right_sample_i;
    full       = (mem_cnt_q == DEPTH_C);
    handshake  = read_valid_q && read_ready_i;
    do_write   = sample_valid_i && !full && !flush_i;
    do_fetch   = (mem_cnt_q != '0) && (!read_valid_q || handshake) && !flush_i;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_cnt_d    = mem_cnt_q;
    read_valid_d = read_valid_q;
    read_data_d  = read_data_q;
    overflow_d   = overflow_q;
    if (flush_i) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      mem_cnt_d    = '0;
      read_valid_d = 1'b0;
      overflow_d   = 1'b0;
    end else begin
      if (do_write) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_fetch) begin
        rd_ptr_d     = rd_ptr_q + AW'(1);
        read_data_d  = mem_q[rd_ptr_q];
        read_valid_d = 1'b1;
      end else if (handshake) begin
        read_valid_d = 1'b0;
      end
      mem_cnt_d = mem_cnt_q + CW'(do_write) - CW'(do_fetch);
      // A full buffer drops the strobe even if a fetch frees a slot this cycle.
      if (sample_valid_i && full) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_cnt_q    <= '0;
      read_valid_q <= 1'b0;
      read_data_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_cnt_q    <= mem_cnt_d;
      read_valid_q <= read_valid_d;
      read_data_q  <= read_data_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (do_write) mem_q[wr_ptr_q] <= sample_sel;
  end

  assign read_data_o    = read_data_q;
  assign read_valid_o   = read_valid_q;
  assign overflow_o     = overflow_q;
  assign fill_level_o   = mem_cnt_q + CW'(read_valid_q);
  assign buffer_ready_o = (fill_level_o >= READY_C);

endmodule

// File: tb/tb_sample_buffer_ctrl.sv
// Bench for sample_buffer_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based model of the buffer.
`timescale 1ns/1ps
module tb_sample_buffer_ctrl;

  localparam int   DEPTH = 4;
  localparam logic SEL   = 1'b1;
  localparam int   RL    = 3;
  localparam int   CW    = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          sample_valid_i = 1'b0;
  logic [23:0]   left_sample_i = '0;
  logic [23:0]   right_sample_i = '0;
  logic          flush_i = 1'b0;
  logic [23:0]   read_data_o;
  logic          read_valid_o;
  logic          read_ready_i = 1'b0;
  logic          buffer_ready_o;
  logic [CW-1:0] fill_level_o;
  logic          overflow_o;

  sample_buffer_ctrl #(.DEPTH(DEPTH), .SELECT_LEFT(SEL), .READY_LEVEL(RL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sample_valid_i(sample_valid_i),
    .left_sample_i(left_sample_i), .right_sample_i(right_sample_i),
    .flush_i(flush_i), .read_data_o(read_data_o), .read_valid_o(read_valid_o),
    .read_ready_i(read_ready_i), .buffer_ready_o(buffer_ready_o),
    .fill_level_o(fill_level_o), .overflow_o(overflow_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  logic [23:0] exp_q[$];

  // Reference model: queue of stored samples plus the presented slot.
  logic [23:0] mdl_q[$];
  logic        mdl_rv;
  logic [23:0] mdl_rd;
  logic        mdl_ovf;

  function automatic void mdl_reset();
    mdl_q.delete();
    mdl_rv  = 1'b0;
    mdl_rd  = '0;
    mdl_ovf = 1'b0;
  endfunction

  function automatic int mdl_fill();
    return mdl_q.size() + (mdl_rv ? 1 : 0);
  endfunction

  function automatic void mdl_edge();
    bit hs, fetch, wr;
    logic [23:0] smp;
    if (rst_i) begin
      mdl_reset();
      return;
    end
    if (flush_i) begin
      mdl_q.delete();
      mdl_rv  = 1'b0;
      mdl_ovf = 1'b0;
      return;
    end
    smp   = SEL ? left_sample_i : right_sample_i;
    hs    = mdl_rv && read_ready_i;
    fetch = (mdl_q.size() > 0) && (!mdl_rv || hs);
    wr    = sample_valid_i && (mdl_q.size() < DEPTH);
    if (sample_valid_i && mdl_q.size() == DEPTH) mdl_ovf = 1'b1;
    if (fetch) begin
      mdl_rd = mdl_q.pop_front();
      mdl_rv = 1'b1;
    end else if (hs) begin
      mdl_rv = 1'b0;
    end
    if (wr) mdl_q.push_back(smp);
  endfunction

  // driver: advance one clock, update the model, settle past the edge
  task automatic tick();
    @(posedge clk_i);
    mdl_edge();
    #1;
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_checks++; if (read_valid_o !== 1'b0) $display("FAIL reset_rv got=%0b exp=0", read_valid_o); else n_pass++;
    n_checks++; if (read_data_o !== 24'h0) $display("FAIL reset_data got=%h exp=000000", read_data_o); else n_pass++;
    n_checks++; if (fill_level_o !== '0) $display("FAIL reset_fill got=%0d exp=0", fill_level_o); else n_pass++;
    n_checks++; if (overflow_o !== 1'b0) $display("FAIL reset_ovf got=%0b exp=0", overflow_o); else n_pass++;
    n_checks++; if (buffer_ready_o !== 1'b0) $display("FAIL reset_bufrdy got=%0b exp=0", buffer_ready_o); else n_pass++;
    rst_i = 1'b0;
  endtask

  task automatic test_single();
    read_ready_i = 1'b0;
    left_sample_i = 24'h800001; right_sample_i = 24'h7ABCDE; sample_valid_i = 1'b1;
    tick();
    sample_valid_i = 1'b0;
    n_checks++; if (read_valid_o !== 1'b0) $display("FAIL single_rv_early got=%0b exp=0", read_valid_o); else n_pass++;
    tick();
    n_checks++; if (read_valid_o !== 1'b1) $display("FAIL single_rv got=%0b exp=1", read_valid_o); else n_pass++;
    n_checks++; if (read_data_o !== 24'h800001) $display("FAIL single_data got=%h exp=800001", read_data_o); else n_pass++;
    n_checks++; if (fill_level_o !== CW'(1)) $display("FAIL single_fill got=%0d exp=1", fill_level_o); else n_pass++;
    n_checks++; if (buffer_ready_o !== 1'b0) $display("FAIL single_bufrdy got=%0b exp=0", buffer_ready_o); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (read_valid_o !== 1'b1 || read_data_o !== 24'h800001)
        $display("FAIL single_hold got=%0b/%h exp=1/800001", read_valid_o, read_data_o);
      else n_pass++;
    end
    read_ready_i = 1'b1;
    tick();
    read_ready_i = 1'b0;
    n_checks++; if (read_valid_o !== 1'b0) $display("FAIL single_consumed got=%0b exp=0", read_valid_o); else n_pass++;
    n_checks++; if (fill_level_o !== '0) $display("FAIL single_fill_end got=%0d exp=0", fill_level_o); else n_pass++;
  endtask

  task automatic test_stream();
    int hs_cnt = 0;
    exp_q.delete();
    read_ready_i = 1'b1;
    for (int cyc = 0; cyc < 52; cyc++) begin
      if (cyc < 40 && cyc % 4 == 0) begin
        sample_valid_i = 1'b1;
        left_sample_i  = 24'($urandom);
        right_sample_i = ~left_sample_i;
        exp_q.push_back(left_sample_i);
      end else sample_valid_i = 1'b0;
      if (read_valid_o && read_ready_i) begin
        hs_cnt++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL stream_extra got=%h exp=none", read_data_o);
        else begin
          logic [23:0] e = exp_q.pop_front();
          if (read_data_o !== e) $display("FAIL stream_data got=%h exp=%h", read_data_o, e);
          else n_pass++;
        end
      end
      tick();
    end
    sample_valid_i = 1'b0;
    n_checks++; if (hs_cnt != 10) $display("FAIL stream_count got=%0d exp=10", hs_cnt); else n_pass++;
    n_checks++; if (fill_level_o !== '0) $display("FAIL stream_fill got=%0d exp=0", fill_level_o); else n_pass++;
    read_ready_i = 1'b0;
  endtask

  task automatic test_overflow();
    int got = 0;
    pulse_flush();
    read_ready_i = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      sample_valid_i = 1'b1; left_sample_i = 24'(i); right_sample_i = 24'hF00000 | 24'(i);
      tick();
    end
    sample_valid_i = 1'b0;
    n_checks++; if (fill_level_o !== CW'(5)) $display("FAIL ovf_fill got=%0d exp=5", fill_level_o); else n_pass++;
    n_checks++; if (overflow_o !== 1'b1) $display("FAIL ovf_flag got=%0b exp=1", overflow_o); else n_pass++;
    n_checks++; if (buffer_ready_o !== 1'b1) $display("FAIL ovf_bufrdy got=%0b exp=1", buffer_ready_o); else n_pass++;
    repeat (3) tick();
    n_checks++; if (overflow_o !== 1'b1) $display("FAIL ovf_sticky got=%0b exp=1", overflow_o); else n_pass++;
    read_ready_i = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (read_valid_o) begin
        got++;
        n_checks++;
        if (read_data_o !== 24'(got)) $display("FAIL ovf_drain got=%h exp=%h", read_data_o, 24'(got));
        else n_pass++;
      end
      tick();
    end
    read_ready_i = 1'b0;
    n_checks++; if (got != 5) $display("FAIL ovf_drain_count got=%0d exp=5", got); else n_pass++;
    n_checks++; if (overflow_o !== 1'b1) $display("FAIL ovf_sticky_drain got=%0b exp=1", overflow_o); else n_pass++;
  endtask

  task automatic test_full_handshake();
    int nxt = 12;
    pulse_flush();
    n_checks++; if (overflow_o !== 1'b0) $display("FAIL fh_flush_ovf got=%0b exp=0", overflow_o); else n_pass++;
    for (int i = 11; i <= 15; i++) begin
      sample_valid_i = 1'b1; left_sample_i = 24'(i); right_sample_i = 24'h0;
      tick();
    end
    sample_valid_i = 1'b1; left_sample_i = 24'd16; read_ready_i = 1'b1;
    tick();
    sample_valid_i = 1'b0; read_ready_i = 1'b0;
    n_checks++; if (fill_level_o !== CW'(4)) $display("FAIL fh_fill got=%0d exp=4", fill_level_o); else n_pass++;
    n_checks++; if (overflow_o !== 1'b1) $display("FAIL fh_ovf got=%0b exp=1", overflow_o); else n_pass++;
    read_ready_i = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (read_valid_o) begin
        n_checks++;
        if (read_data_o !== 24'(nxt)) $display("FAIL fh_drain got=%h exp=%h", read_data_o, 24'(nxt));
        else n_pass++;
        nxt++;
      end
      tick();
    end
    read_ready_i = 1'b0;
    n_checks++; if (nxt != 16) $display("FAIL fh_drain_count got=%0d exp=16", nxt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic        stall;
    logic [23:0] held;
    pulse_flush();
    exp_q.delete();
    read_ready_i = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      sample_valid_i = (cyc < 8);
      left_sample_i  = 24'($urandom);
      right_sample_i = 24'($urandom);
      if (sample_valid_i && mdl_q.size() < DEPTH) exp_q.push_back(left_sample_i);
      stall = read_valid_o && !read_ready_i;
      held  = read_data_o;
      if (read_valid_o && read_ready_i) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL b2b_extra got=%h exp=none", read_data_o);
        else begin
          logic [23:0] e = exp_q.pop_front();
          if (read_data_o !== e) $display("FAIL b2b_data got=%h exp=%h", read_data_o, e);
          else n_pass++;
        end
      end
      tick();
      if (stall) begin
        n_checks++;
        if (read_valid_o !== 1'b1 || read_data_o !== held)
          $display("FAIL b2b_hold got=%0b/%h exp=1/%h", read_valid_o, read_data_o, held);
        else n_pass++;
      end
      read_ready_i = ~read_ready_i;
    end
    sample_valid_i = 1'b0; read_ready_i = 1'b0;
    n_checks++; if (exp_q.size() != 0) $display("FAIL b2b_left got=%0d exp=0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_flush();
    pulse_flush();
    read_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_valid_i = 1'b1; left_sample_i = 24'h100 + 24'(i); right_sample_i = 24'h0;
      tick();
    end
    sample_valid_i = 1'b0;
    tick();
    n_checks++; if (fill_level_o !== CW'(3)) $display("FAIL flush_pre_fill got=%0d exp=3", fill_level_o); else n_pass++;
    n_checks++; if (buffer_ready_o !== 1'b1) $display("FAIL flush_pre_bufrdy got=%0b exp=1", buffer_ready_o); else n_pass++;
    flush_i = 1'b1; sample_valid_i = 1'b1; left_sample_i = 24'hDEAD01; read_ready_i = 1'b1;
    tick();
    flush_i = 1'b0; sample_valid_i = 1'b0; read_ready_i = 1'b0;
    n_checks++; if (read_valid_o !== 1'b0) $display("FAIL flush_rv got=%0b exp=0", read_valid_o); else n_pass++;
    n_checks++; if (fill_level_o !== '0) $display("FAIL flush_fill got=%0d exp=0", fill_level_o); else n_pass++;
    n_checks++; if (buffer_ready_o !== 1'b0) $display("FAIL flush_bufrdy got=%0b exp=0", buffer_ready_o); else n_pass++;
    sample_valid_i = 1'b1; left_sample_i = 24'h123456; right_sample_i = 24'h654321;
    tick();
    sample_valid_i = 1'b0;
    tick();
    n_checks++;
    if (read_valid_o !== 1'b1 || read_data_o !== 24'h123456)
      $display("FAIL flush_next got=%0b/%h exp=1/123456", read_valid_o, read_data_o);
    else n_pass++;
    read_ready_i = 1'b1;
    tick();
    read_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    read_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_valid_i = 1'b1; left_sample_i = 24'h200 + 24'(i); right_sample_i = 24'h0;
      tick();
    end
    rst_i = 1'b1;
    #1;
    mdl_reset();
    n_checks++; if (read_valid_o !== 1'b0) $display("FAIL rstmid_rv got=%0b exp=0", read_valid_o); else n_pass++;
    n_checks++; if (read_data_o !== 24'h0) $display("FAIL rstmid_data got=%h exp=000000", read_data_o); else n_pass++;
    n_checks++; if (fill_level_o !== '0) $display("FAIL rstmid_fill got=%0d exp=0", fill_level_o); else n_pass++;
    tick();
    rst_i = 1'b0;
    sample_valid_i = 1'b1; left_sample_i = 24'hABCDEF; right_sample_i = 24'h111111;
    tick();
    sample_valid_i = 1'b0;
    n_checks++; if (fill_level_o !== CW'(1)) $display("FAIL rstmid_first got=%0d exp=1", fill_level_o); else n_pass++;
    tick();
    n_checks++;
    if (read_valid_o !== 1'b1 || read_data_o !== 24'hABCDEF)
      $display("FAIL rstmid_next got=%0b/%h exp=1/abcdef", read_valid_o, read_data_o);
    else n_pass++;
    read_ready_i = 1'b1;
    tick();
    read_ready_i = 1'b0;
  endtask

  task automatic test_random();
    pulse_flush();
    for (int cyc = 0; cyc < 400; cyc++) begin
      sample_valid_i = ($urandom_range(0, 9) < 6);
      read_ready_i   = ($urandom_range(0, 1) == 1);
      flush_i        = ($urandom_range(0, 49) == 0);
      left_sample_i  = 24'($urandom);
      right_sample_i = 24'($urandom);
      tick();
      n_checks++;
      if (read_valid_o !== mdl_rv || fill_level_o !== CW'(mdl_fill()) || overflow_o !== mdl_ovf ||
          buffer_ready_o !== (mdl_fill() >= RL))
        $display("FAIL rand_status cyc=%0d got rv=%0b fill=%0d ovf=%0b rdy=%0b exp rv=%0b fill=%0d ovf=%0b",
                 cyc, read_valid_o, fill_level_o, overflow_o, buffer_ready_o, mdl_rv, mdl_fill(), mdl_ovf);
      else n_pass++;
      if (mdl_rv) begin
        n_checks++;
        if (read_data_o !== mdl_rd) $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, read_data_o, mdl_rd);
        else n_pass++;
      end
    end
    sample_valid_i = 1'b0; read_ready_i = 1'b0; flush_i = 1'b0;
  endtask

  initial begin
    mdl_reset();
    test_reset();
    test_single();
    test_stream();
    test_overflow();
    test_full_handshake();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
